rv_instr_encoder_loader: RTL

Sequential RV32I instruction encoder and instruction-memory loader. It accepts a stream of symbolic instruction requests (op code, register indices, immediate) over a valid/ready handshake and packs each one into a 32-bit RV32I word, covering the same subset the pipeline controller decodes. It writes the words to consecutive instruction-memory addresses and terminates the program with a self-loop halt. It sits between the test/boot host and the instruction memory of the pipelined core.

---
 rtl/rv_instr_encoder_loader_if.sv | 30 +++
 rtl/rv_instr_encoder_loader.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/rv_instr_encoder_loader_if.sv
// Host-side request stream and instruction-memory write port of the RV32I encoder/loader.
// The master side is the boot/test host, and the slave side is the loader.
interface rv_instr_encoder_loader_if #(
    parameter int ADDR_W = 10
);
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        in_op;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [31:0]       in_imm;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   count;

    modport master (
        output start, in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm,
        input  in_ready, mem_we, mem_addr, mem_wdata, done, err, count
    );

    modport slave (
        input  start, in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm,
        output in_ready, mem_we, mem_addr, mem_wdata, done, err, count
    );
endinterface

// File: rtl/rv_instr_encoder_loader.sv
// Packs symbolic requests into RV32I words and writes them to consecutive imem words, ending with a halt.
// Each write appears one cycle after acceptance, at one word per cycle; in_ready is low unless in RUN with a spare slot left for the halt.
module rv_instr_encoder_loader #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input logic                       clk,
    input logic                       rst,
    rv_instr_encoder_loader_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [ADDR_W:0] C_LAST = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [31:0]     C_HALT = 32'h0000_006F;

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W:0]   r_count;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic              r_done;
    logic              r_err;

    logic [31:0] w_enc;
    logic        w_legal;
    logic        w_is_end;
    logic        w_in_ready;
    logic        w_wr;
    logic [31:0] w_wr_data;
    logic        w_clear;
    logic        w_set_err;
    logic        w_set_done;

    logic [4:0]  w_rd;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [31:0] w_imm;

    assign w_rd  = bus.in_rd;
    assign w_rs1 = bus.in_rs1;
    assign w_rs2 = bus.in_rs2;
    assign w_imm = bus.in_imm;

    // Unused fields stay zero, and the immediate bits above each format's field are dropped.
    always_comb begin
        w_enc    = '0;
        w_legal  = 1'b1;
        w_is_end = 1'b0;
        case (bus.in_op)
            5'd0:  w_enc = {7'b0000000, w_rs2, w_rs1, 3'b000, w_rd, 7'b0110011};
            5'd1:  w_enc = {7'b0100000, w_rs2, w_rs1, 3'b000, w_rd, 7'b0110011};
            5'd2:  w_enc = {7'b0000000, w_rs2, w_rs1, 3'b111, w_rd, 7'b0110011};
            5'd3:  w_enc = {7'b0000000, w_rs2, w_rs1, 3'b110, w_rd, 7'b0110011};
            5'd4:  w_enc = {7'b0000000, w_rs2, w_rs1, 3'b010, w_rd, 7'b0110011};
            5'd5:  w_enc = {w_imm[11:0], w_rs1, 3'b010, w_rd, 7'b0000011};
            5'd6:  w_enc = {w_imm[11:0], w_rs1, 3'b000, w_rd, 7'b0010011};
            5'd7:  w_enc = {w_imm[11:0], w_rs1, 3'b100, w_rd, 7'b0010011};
            5'd8:  w_enc = {w_imm[11:0], w_rs1, 3'b110, w_rd, 7'b0010011};
            5'd9:  w_enc = {w_imm[11:0], w_rs1, 3'b010, w_rd, 7'b0010011};
            5'd10: w_enc = {w_imm[11:0], w_rs1, 3'b000, w_rd, 7'b1100111};
            5'd11: w_enc = {w_imm[11:5], w_rs2, w_rs1, 3'b010, w_imm[4:0], 7'b0100011};
            5'd12: w_enc = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12], w_rd, 7'b1101111};
            5'd13: w_enc = {w_imm[12], w_imm[10:5], w_rs2, w_rs1, 3'b000, w_imm[4:1], w_imm[11], 7'b1100011};
            5'd14: w_enc = {w_imm[12], w_imm[10:5], w_rs2, w_rs1, 3'b001, w_imm[4:1], w_imm[11], 7'b1100011};
            5'd15: w_enc = {w_imm[12], w_imm[10:5], w_rs2, w_rs1, 3'b100, w_imm[4:1], w_imm[11], 7'b1100011};
            5'd16: w_enc = {w_imm[12], w_imm[10:5], w_rs2, w_rs1, 3'b101, w_imm[4:1], w_imm[11], 7'b1100011};
            5'd17: w_enc = {w_imm[31:12], w_rd, 7'b0110111};
            5'd31: begin
                w_enc    = C_HALT;
                w_is_end = 1'b1;
            end
            default: w_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_in_ready   = 1'b0;
        w_wr         = 1'b0;
        w_wr_data    = w_enc;
        w_clear      = 1'b0;
        w_set_err    = 1'b0;
        w_set_done   = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    w_next_state = S_RUN;
                    w_clear      = 1'b1;
                end
            end
            S_RUN: begin
                w_in_ready = (r_count < C_LAST);
                // Only the reserved last slot is left, so the loader closes the program itself.
                if (!w_in_ready) begin
                    w_wr         = 1'b1;
                    w_wr_data    = C_HALT;
                    w_set_err    = 1'b1;
                    w_set_done   = 1'b1;
                    w_next_state = S_DONE;
                end else if (bus.in_valid) begin
                    if (w_is_end) begin
                        w_wr         = 1'b1;
                        w_wr_data    = C_HALT;
                        w_set_done   = 1'b1;
                        w_next_state = S_DONE;
                    end else if (w_legal) begin
                        w_wr = 1'b1;
                    end else begin
                        w_set_err = 1'b1;
                    end
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // count also serves as the write pointer; mem_addr/mem_wdata keep their last written values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count     <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_mem_we <= w_wr;
            if (w_clear) begin
                r_count <= '0;
                r_done  <= 1'b0;
                r_err   <= 1'b0;
            end else begin
                if (w_wr) begin
                    r_mem_addr  <= r_count[ADDR_W-1:0];
                    r_mem_wdata <= w_wr_data;
                    r_count     <= r_count + 1'b1;
                end
                if (w_set_err) begin
                    r_err <= 1'b1;
                end
                if (w_set_done) begin
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
    assign bus.count     = r_count;
endmodule
